itof_pipe: RTL and testbench
============================

// Module: itof_pipe
// PURPOSE
//   Pipelined signed 32-bit integer to IEEE-754 single conversion for the FPU (itof instruction).
//   It is the reverse path of the float-to-int unit and uses the same rm semantics:
//   rm=0 rounds to nearest, ties to even; rm=1 rounds toward -inf (floor).
//   3-stage pipeline with a valid/ready handshake, so the core's FPU dispatch can stall it.
// PARAMETERS
//   (none; widths are fixed at 32-bit int and binary32)
// PORTS
//   clk        in   1   sole clock, rising edge
//   rst        in   1   asynchronous, active-high reset
//   in_valid   in   1   x/rm are valid this cycle
//   in_ready   out  1   unit accepts input this cycle
//   x          in   32  two's-complement integer operand
//   rm         in   1   0 = round to nearest even, 1 = floor
//   out_valid  out  1   y is valid
//   out_ready  in   1   consumer accepts y this cycle
//   y          out  32  binary32 result {s, e[7:0], m[22:0]}
// BEHAVIOUR
//   Reset: asserting rst clears every stage valid bit and sets y=0 and out_valid=0 asynchronously.
//     In-flight operations are dropped; nothing is replayed. in_ready=1 after reset.
//   Handshake: the pipe advances when adv = ~out_valid | out_ready. in_ready = adv.
//     Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
//     While out_valid=1 and out_ready=0, all stages hold and y stays stable.
//     Bubbles do not compress while stalled (global stall).
//   Latency: exactly 3 clk edges from input transfer to out_valid. Throughput is 1/cycle with no stall.
//   S1 (register): s = x[31]; a = s ? -x : x, taken as a 32-bit unsigned value (0x80000000 -> 2^31); rm.
//   S2 (register): lz = lzc32(a); n = a << lz (n[31] = 1 unless a = 0); zero flag = (a == 0).
//   S3 (register, drives y):
//     e0 = 158 - lz
//     mant = n[30:8], g = n[7], st = |n[6:0]
//     RNE: up = g & (st | mant[0])
//     floor: up = s & (g | st)        // magnitude rounds up only for negatives
//     {c, m} = mant + up              // carry c increments e0
//     e = e0 + c
//   Special cases:
//     a = 0 -> y = 0x00000000 (never -0), regardless of rm.
//     Overflow cannot occur: max e = 158; 0x7FFFFFFF in RNE -> 0x4F000000.
//   Simultaneous output pop and input push in the same cycle are both accepted (adv=1).
//   No X propagation: held stages keep their registers; invalid stages may carry junk,
//     but y is only meaningful when out_valid=1.
// STRUCTURE
//   Shared package fpu_pkg:
//     FP_BIAS = 8'd127
//     FP_EXP_INT_MAX = 8'd158
//     FP_MANT_W = 23
//     RM_RNE = 1'b0
//     RM_FLOOR = 1'b1
//     the float field-slicing functions, also used by ftoi
//   Sub-module lzc32: combinational 32-bit leading-zero counter, 6-bit output (32 when input = 0).
//     Tree implementation; unit-tested separately.
//   Remainder (stage registers, rounding, handshake) is inline in itof_pipe.
// TESTING
//   1. x=1, rm=0 -> y=0x3F800000; x=-1 -> 0xBF800000; x=0, rm=1 -> 0x00000000;
//      out_valid exactly 3 cycles after accept.
//   2. x=0x80000000 -> 0xCF000000; x=0x7FFFFFFF: rm=0 -> 0x4F000000, rm=1 -> 0x4EFFFFFF.
//   3. Ties: x=16777217, rm=0 -> 0x4B800000; x=16777219, rm=0 -> 0x4B800002;
//      x=-16777217, rm=1 -> 0xCB800001; x=16777217, rm=1 -> 0x4B800000.
//   4. Back-to-back stream of 8 inputs with out_ready=1 -> 8 results in order,
//      one per cycle, in_ready always 1.
//   5. Hold out_ready=0 for 5 cycles with 3 ops in flight -> y/out_valid stable,
//      in_ready=0, no loss or duplication after release.
//   6. Assert rst mid-stream -> out_valid drops immediately (async), y=0;
//      first post-reset op still has 3-cycle latency.
//   Random: 1e6 random x/rm compared against a reference model (C cast with fesetround), zero mismatches.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU constants and binary32 field helpers, used by both itof and ftoi.
package fpu_pkg;

    localparam logic [7:0] FP_BIAS        = 8'd127;
    localparam logic [7:0] FP_EXP_INT_MAX = 8'd158;
    localparam int         FP_MANT_W      = 23;

    localparam logic RM_RNE   = 1'b0;
    localparam logic RM_FLOOR = 1'b1;

    function automatic logic fp_sign(input logic [31:0] f);
        return f[31];
    endfunction

    function automatic logic [7:0] fp_exp(input logic [31:0] f);
        return f[30:23];
    endfunction

    function automatic logic [FP_MANT_W-1:0] fp_mant(input logic [31:0] f);
        return f[FP_MANT_W-1:0];
    endfunction

    function automatic logic [31:0] fp_pack(input logic s, input logic [7:0] e,
                                            input logic [FP_MANT_W-1:0] m);
        return {s, e, m};
    endfunction

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter built as a log2 tree of (valid, count) pairs.
module lzc32 (
    input  logic [31:0] a,
    output logic [5:0]  lz
);

    logic [15:0] v1;
    logic [0:0]  c1 [16];
    logic [7:0]  v2;
    logic [1:0]  c2 [8];
    logic [3:0]  v3;
    logic [2:0]  c3 [4];
    logic [1:0]  v4;
    logic [3:0]  c4 [2];
    logic        v5;
    logic [4:0]  c5;

    // Each node reports "any one below me" and the zero count within its span;
    // the upper half wins when it holds a one, otherwise its full width is added.
    always_comb begin
        for (int j = 0; j < 16; j++) begin
            v1[j] = a[2*j+1] | a[2*j];
            c1[j] = ~a[2*j+1];
        end
        for (int j = 0; j < 8; j++) begin
            v2[j] = v1[2*j+1] | v1[2*j];
            c2[j] = v1[2*j+1] ? {1'b0, c1[2*j+1]} : {1'b1, c1[2*j]};
        end
        for (int j = 0; j < 4; j++) begin
            v3[j] = v2[2*j+1] | v2[2*j];
            c3[j] = v2[2*j+1] ? {1'b0, c2[2*j+1]} : {1'b1, c2[2*j]};
        end
        for (int j = 0; j < 2; j++) begin
            v4[j] = v3[2*j+1] | v3[2*j];
            c4[j] = v3[2*j+1] ? {1'b0, c3[2*j+1]} : {1'b1, c3[2*j]};
        end
        v5 = v4[1] | v4[0];
        c5 = v4[1] ? {1'b0, c4[1]} : {1'b1, c4[0]};
        lz = v5 ? {1'b0, c5} : 6'd32;
    end

endmodule

// File: rtl/itof_pipe.sv
// Three-stage signed int32 -> binary32 converter with RNE/floor rounding and a
// global-stall valid/ready handshake.
module itof_pipe
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    input  logic        rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y
);

    logic adv;
    logic v1, v2, v3;

    // Stage 1: sign and magnitude (0x80000000 negates to itself = 2^31 unsigned)
    logic        s1_sign, s1_rm;
    logic [31:0] s1_mag;

    // Stage 2: normalised fraction below the leading one
    logic        s2_sign, s2_rm, s2_zero;
    logic [5:0]  s2_lz;
    logic [30:0] s2_frac;

    logic [5:0]  lz_w;

    logic [7:0]           e0, e_rnd;
    logic [FP_MANT_W-1:0] mant, m_rnd;
    logic                 g, st, up, carry;
    logic [31:0]          y_next;

    assign adv       = ~v3 | out_ready;
    assign in_ready  = adv;
    assign out_valid = v3;

    lzc32 u_lzc (
        .a  (s1_mag),
        .lz (lz_w)
    );

    always_comb begin
        e0    = FP_EXP_INT_MAX - {2'b00, s2_lz};
        mant  = s2_frac[30:8];
        g     = s2_frac[7];
        st    = |s2_frac[6:0];
        up    = (s2_rm == RM_RNE) ? (g & (st | mant[0])) : (s2_sign & (g | st));
        {carry, m_rnd} = {1'b0, mant} + {{FP_MANT_W{1'b0}}, up};
        e_rnd  = e0 + {7'd0, carry};
        y_next = s2_zero ? 32'h0000_0000 : fp_pack(s2_sign, e_rnd, m_rnd);
    end

    // NOTE: sequential state uses non-blocking (<=) so every stage samples the
    // previous stage's pre-edge value; blocking here would collapse the pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            y  <= 32'h0000_0000;
        end else if (adv) begin
            v1 <= in_valid;
            v2 <= v1;
            v3 <= v2;
            y  <= y_next;
        end
    end

    // NOTE: the datapath registers are deliberately not reset; the valid bits
    // alone decide whether their contents mean anything.
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_sign <= x[31];
            s1_rm   <= rm;
            s1_mag  <= x[31] ? (32'd0 - x) : x;
            s2_sign <= s1_sign;
            s2_rm   <= s1_rm;
            s2_zero <= (s1_mag == 32'd0);
            s2_lz   <= lz_w;
            s2_frac <= 31'(s1_mag << lz_w);
        end
    end

endmodule

// File: tb/tb_itof_pipe.sv
// Self-checking bench for itof_pipe: directed corner cases plus a randomized
// stream scored against an arithmetic reference model.
module tb_itof_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] x = 32'd0;
    logic        rm = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] y;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;
    logic [31:0] exp_q[$];

    itof_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .rm        (rm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: locate the leading one, keep 24 significant bits, round the
    // discarded remainder by comparing it with half an ulp.
    function automatic logic [31:0] ref_itof(input logic [31:0] xi, input logic rmi);
        longint v, mag, q, rem, half;
        bit     neg, up;
        int     p, sh;
        v    = $signed(xi);
        neg  = (v < 0);
        mag  = neg ? -v : v;
        up   = 1'b0;
        p    = 0;
        if (mag == 0) return 32'h0000_0000;
        for (int i = 0; i < 32; i++) if (((mag >> i) & 1) == 1) p = i;
        if (p <= 23) begin
            q = mag << (23 - p);
        end else begin
            sh   = p - 23;
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = 64'sd1 << (sh - 1);
            if (rmi == 1'b0) up = (rem > half) || (rem == half && q[0]);
            else             up = neg && (rem != 0);
        end
        q = q + (up ? 1 : 0);
        if (q == (64'sd1 << 24)) begin
            q = q >> 1;
            p = p + 1;
        end
        return {neg, 8'(p + 127), q[22:0]};
    endfunction

    // One cycle, entered and left on a falling edge; scores any output pop and
    // records any accepted input.
    task automatic step(input logic iv, input logic [31:0] ix, input logic irm,
                        input logic ordy, input logic use_const, input logic [31:0] cval);
        in_valid  = iv;
        x         = ix;
        rm        = irm;
        out_ready = ordy;
        #1;
        if (out_valid && ordy) begin
            pops++;
            if (exp_q.size() == 0) check("spurious_out", 32'd1, 32'd0);
            else                   check("y", y, exp_q.pop_front());
        end
        if (iv && in_ready) exp_q.push_back(use_const ? cval : ref_itof(ix, irm));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_c(input logic [31:0] ix, input logic irm, input logic [31:0] e);
        step(1'b1, ix, irm, 1'b1, 1'b1, e);
    endtask

    task automatic push_m(input logic [31:0] ix, input logic irm);
        step(1'b1, ix, irm, 1'b1, 1'b0, 32'd0);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 32'd0, 1'b0, ordy, 1'b0, 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) idle(1'b1);
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    function automatic logic [31:0] rand_x();
        logic [31:0] r;
        case ($urandom_range(0, 3))
            0:       r = $urandom;
            1:       r = 32'($urandom_range(0, 300));
            2:       r = 32'($urandom) >> $urandom_range(0, 31);
            default: r = (32'd1 << $urandom_range(24, 30)) + 32'($urandom_range(0, 3));
        endcase
        if ($urandom_range(0, 1) == 1) r = 32'd0 - r;
        return r;
    endfunction

    initial begin
        logic [31:0] held_y;
        int          pops0;

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_y", y, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Basic values and 3-edge latency
        push_c(32'd1, 1'b0, 32'h3F80_0000);
        check("lat_edge1", {31'd0, out_valid}, 32'd0);
        idle(1'b1);
        check("lat_edge2", {31'd0, out_valid}, 32'd0);
        idle(1'b1);
        check("lat_edge3", {31'd0, out_valid}, 32'd1);
        drain();
        push_c(32'hFFFF_FFFF, 1'b0, 32'hBF80_0000);
        push_c(32'd0, 1'b1, 32'h0000_0000);
        push_c(32'd0, 1'b0, 32'h0000_0000);
        drain();

        // Extremes and ties
        push_c(32'h8000_0000, 1'b0, 32'hCF00_0000);
        push_c(32'h7FFF_FFFF, 1'b0, 32'h4F00_0000);
        push_c(32'h7FFF_FFFF, 1'b1, 32'h4EFF_FFFF);
        push_c(32'd16777217, 1'b0, 32'h4B80_0000);
        push_c(32'd16777219, 1'b0, 32'h4B80_0002);
        push_c(-32'sd16777217, 1'b1, 32'hCB80_0001);
        push_c(32'd16777217, 1'b1, 32'h4B80_0000);
        push_c(32'hFFFF_FFFF, 1'b1, 32'hBF80_0000);
        drain();

        // Back-to-back stream: one result per cycle, never back-pressured
        pops0 = pops;
        for (int i = 0; i < 8; i++) begin
            push_m(rand_x(), 1'(i));
            check("stream_in_ready", {31'd0, in_ready}, 32'd1);
        end
        for (int i = 0; i < 3; i++) idle(1'b1);
        check("stream_pops", 32'(pops - pops0), 32'd8);
        check("stream_empty", 32'(exp_q.size()), 32'd0);

        // Global stall with three ops in flight
        pops0 = pops;
        push_m(32'd5, 1'b0);
        push_m(-32'sd100000001, 1'b1);
        push_m(32'd33554435, 1'b0);
        check("stall_full", {31'd0, out_valid}, 32'd1);
        held_y = y;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'd77, 1'b0, 1'b0, 1'b0, 32'd0);
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_y", y, held_y);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        drain();
        check("stall_pops", 32'(pops - pops0), 32'd3);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 4; i++) push_m(32'd1000 + 32'(i), 1'b0);
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_y", y, 32'd0);
        check("async_in_ready", {31'd0, in_ready}, 32'd1);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        idle(1'b1);
        check("post_rst_idle", {31'd0, out_valid}, 32'd0);
        push_c(32'd3, 1'b0, 32'h4040_0000);
        check("post_lat1", {31'd0, out_valid}, 32'd0);
        idle(1'b1);
        check("post_lat2", {31'd0, out_valid}, 32'd0);
        idle(1'b1);
        check("post_lat3", {31'd0, out_valid}, 32'd1);
        drain();

        // Randomized traffic with random bubbles and back-pressure
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 4) != 0, rand_x(), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0, 1'b0, 32'd0);
        end
        drain();
        check("final_idle", {31'd0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
